// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, ALU op encodings and helpers
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int IMM_W    = 16;
  localparam int ALU_OP_W = 3;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  function automatic logic [DATA_W-1:0] sign_extend_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/s2_operand_fetch_if.sv
// rtl/s2_operand_fetch_if.sv - S1 decode fields, write-back port and S2/S3 boundary bundle
interface s2_operand_fetch_if
  import cpu_pkg::*;
  ();

  logic [ADDR_W-1:0]   s1_read_select1;
  logic [ADDR_W-1:0]   s1_read_select2;
  logic [ADDR_W-1:0]   s1_write_select;
  logic                s1_write_enable;
  logic [IMM_W-1:0]    s1_imm;
  logic                s1_data_src;
  logic [ALU_OP_W-1:0] s1_alu_op;
  logic                stall;

  logic [ADDR_W-1:0]   wb_write_select;
  logic                wb_write_enable;
  logic [DATA_W-1:0]   wb_write_data;

  logic [DATA_W-1:0]   s2_operand_a;
  logic [DATA_W-1:0]   s2_operand_b;
  logic [ADDR_W-1:0]   s2_write_select;
  logic                s2_write_enable;
  logic [ALU_OP_W-1:0] s2_alu_op;
  logic                s2_valid;

  modport master (
    output s1_read_select1, s1_read_select2, s1_write_select, s1_write_enable,
    output s1_imm, s1_data_src, s1_alu_op, stall,
    output wb_write_select, wb_write_enable, wb_write_data,
    input  s2_operand_a, s2_operand_b, s2_write_select, s2_write_enable,
    input  s2_alu_op, s2_valid
  );

  modport slave (
    input  s1_read_select1, s1_read_select2, s1_write_select, s1_write_enable,
    input  s1_imm, s1_data_src, s1_alu_op, stall,
    input  wb_write_select, wb_write_enable, wb_write_data,
    output s2_operand_a, s2_operand_b, s2_write_select, s2_write_enable,
    output s2_alu_op, s2_valid
  );

endinterface

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - architectural register file, 2 async reads, 1 sync write, r0 hardwired
module regfile_2r1w
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_sel_a,
  input  logic [ADDR_W-1:0] rd_sel_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_live;

  assign wr_live = wr_en && (wr_sel != ZERO_REG);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_sel] <= wr_data;
    end
  end

  // A write landing this edge is forwarded so the reader sees it without a cycle of delay.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_sel_a != ZERO_REG) rd_data_a = (wr_live && wr_sel == rd_sel_a) ? wr_data : regs[rd_sel_a];
    if (rd_sel_b != ZERO_REG) rd_data_b = (wr_live && wr_sel == rd_sel_b) ? wr_data : regs[rd_sel_b];
  end

endmodule

// File: rtl/s2_operand_fetch.sv
// rtl/s2_operand_fetch.sv - operand fetch stage: regfile read, imm mux, S2/S3 pipeline registers
module s2_operand_fetch
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  s2_operand_fetch_if.slave  bus
);

  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] operand_b_next;

  regfile_2r1w u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_sel_a  (bus.s1_read_select1),
    .rd_sel_b  (bus.s1_read_select2),
    .rd_data_a (reg_a),
    .rd_data_b (reg_b),
    .wr_sel    (bus.wb_write_select),
    .wr_en     (bus.wb_write_enable),
    .wr_data   (bus.wb_write_data)
  );

  assign operand_b_next = bus.s1_data_src ? sign_extend_imm(bus.s1_imm) : reg_b;

  // Stall freezes the whole boundary, valid included; the regfile keeps taking write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.s2_operand_a    <= '0;
      bus.s2_operand_b    <= '0;
      bus.s2_write_select <= '0;
      bus.s2_write_enable <= 1'b0;
      bus.s2_alu_op       <= '0;
      bus.s2_valid        <= 1'b0;
    end else if (!bus.stall) begin
      bus.s2_operand_a    <= reg_a;
      bus.s2_operand_b    <= operand_b_next;
      bus.s2_write_select <= bus.s1_write_select;
      bus.s2_write_enable <= bus.s1_write_enable;
      bus.s2_alu_op       <= bus.s1_alu_op;
      bus.s2_valid        <= 1'b1;
    end
  end

endmodule
